// File: rtl/epx_round_clamp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : epx_round_clamp                                              |
// | Description : Pre-conditioning stage for the e^x lookup. Rounds an FP32    |
// |               operand to the nearest integer (ties to even), clamps it to  |
// |               [-MAX_INT, +MAX_INT] and repacks it as a canonical FP32      |
// |               integer so it always matches a LUT key exactly.              |
// |               Two-stage pipeline, one sample per cycle, no backpressure.   |
// | Ports       : clk         - rising-edge clock                              |
// |               reset       - synchronous active-high reset                  |
// |               valid_in    - in carries a sample this cycle                 |
// |               in          - FP32 operand                                   |
// |               out         - rounded, clamped FP32 integer                  |
// |               valid_out   - out carries a new sample this cycle            |
// |               clamped     - sample on out was saturated or NaN             |
// |               clamp_count - saturating count of clamped samples            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module epx_round_clamp #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_INT    = 31,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  valid_out,
  output logic                  clamped,
  output logic [CNT_WIDTH-1:0]  clamp_count
);

  localparam logic [8:0] C_MAX9 = 9'(MAX_INT);
  localparam logic [7:0] C_MAX8 = 8'(MAX_INT);

  // ---------------------------------------------------------------------------
  // Stage 1: unpack, round to nearest integer (ties to even)
  // ---------------------------------------------------------------------------
  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic [3:0]  w_sh;
  logic [31:0] w_t;
  logic        w_round;
  logic        w_s1_sign;
  logic [8:0]  w_s1_mag;
  logic        w_s1_flag;

  assign w_sign = in[31];
  assign w_exp  = in[30:23];
  assign w_man  = in[22:0];

  // For exponents 126..134 the low nibble of (e - 126) is 0..8. Shifting the
  // 24-bit significand by that amount places the binary point between bit 24
  // and bit 23: [31:24] integer part, [23] guard, [22:0] sticky bits.
  assign w_sh    = w_exp[3:0] - 4'd14;
  assign w_t     = {8'b0, 1'b1, w_man} << w_sh;
  assign w_round = w_t[23] & ((|w_t[22:0]) | w_t[24]);

  always_comb begin
    w_s1_sign = w_sign;
    w_s1_mag  = '0;
    w_s1_flag = 1'b0;
    if (w_exp == 8'd255) begin
      w_s1_flag = 1'b1;
      if (w_man != '0) begin
        // NaN: emitted as +0 with the clamp flag set
        w_s1_sign = 1'b0;
        w_s1_mag  = '0;
      end else begin
        w_s1_mag  = C_MAX9;
      end
    end else if (w_exp >= 8'd135) begin
      // |x| >= 256 is beyond any legal clamp magnitude
      w_s1_flag = 1'b1;
      w_s1_mag  = C_MAX9;
    end else if (w_exp >= 8'd126) begin
      w_s1_mag  = {1'b0, w_t[31:24]} + {8'b0, w_round};
    end
  end

  logic       r_s1_valid;
  logic       r_s1_sign;
  logic [8:0] r_s1_mag;
  logic       r_s1_flag;

  // ---------------------------------------------------------------------------
  // Stage 2: clamp and repack as FP32
  // ---------------------------------------------------------------------------
  logic        w_over;
  logic [7:0]  w_mag8;
  logic        w_flag;
  logic [2:0]  w_msb;
  logic [22:0] w_mag23;
  logic [4:0]  w_shamt;
  logic [22:0] w_mant;
  logic [7:0]  w_bexp;
  logic [31:0] w_packed;

  assign w_over = (r_s1_mag > C_MAX9);
  assign w_mag8 = w_over ? C_MAX8 : r_s1_mag[7:0];
  assign w_flag = r_s1_flag | w_over;

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < 8; i++) begin
      if (w_mag8[i]) begin
        w_msb = 3'(i);
      end
    end
  end

  // Shifting the MSB up to bit 23 pushes it out of the 23-bit field, leaving
  // the remaining bits left-aligned as the mantissa.
  assign w_mag23  = {15'b0, w_mag8};
  assign w_shamt  = 5'd23 - {2'b0, w_msb};
  assign w_mant   = w_mag23 << w_shamt;
  assign w_bexp   = 8'd127 + {5'b0, w_msb};
  assign w_packed = (w_mag8 == '0) ? 32'h0000_0000 : {r_s1_sign, w_bexp, w_mant};

  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_out_valid;
  logic                  r_clamped;
  logic [CNT_WIDTH-1:0]  r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_mag    <= '0;
      r_s1_flag   <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_clamped   <= 1'b0;
      r_count     <= '0;
    end else begin
      r_s1_valid  <= valid_in;
      if (valid_in) begin
        r_s1_sign <= w_s1_sign;
        r_s1_mag  <= w_s1_mag;
        r_s1_flag <= w_s1_flag;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out     <= w_packed;
        r_clamped <= w_flag;
        // Count moves with the sample so it already includes the sample on out
        if (w_flag && (r_count != '1)) begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign out         = r_out;
  assign valid_out   = r_out_valid;
  assign clamped     = r_clamped;
  assign clamp_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_epx_round_clamp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_epx_round_clamp                                           |
// | Description : Self-checking bench for epx_round_clamp. Two instances share |
// |               the stimulus: default counter width and a 4-bit counter.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_epx_round_clamp;

  localparam int MAX_INT = 31;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] in;

  logic [31:0] out_a;
  logic        valid_a;
  logic        clamped_a;
  logic [15:0] count_a;

  logic [31:0] out_b;
  logic        valid_b;
  logic        clamped_b;
  logic [3:0]  count_b;

  epx_round_clamp #(.DATA_WIDTH(32), .MAX_INT(MAX_INT), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .in(in),
    .out(out_a), .valid_out(valid_a), .clamped(clamped_a), .clamp_count(count_a)
  );

  epx_round_clamp #(.DATA_WIDTH(32), .MAX_INT(MAX_INT), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .reset(reset), .valid_in(valid_in), .in(in),
    .out(out_b), .valid_out(valid_b), .clamped(clamped_b), .clamp_count(count_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] o;
    bit          c;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cnt_model = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: exact rational value sig * 2^(e-150), rounded half-to-even
  function automatic void model(input logic [31:0] x, output logic [31:0] o, output bit c);
    bit          s;
    int          e;
    longint      sig, q0, r, half, n, d;
    int          p;
    s = x[31];
    e = int'(x[30:23]);
    c = 1'b0;
    o = 32'h0;
    if (e == 255 && x[22:0] != 0) begin
      c = 1'b1;
      return;
    end
    if (e == 255 || e >= 135) begin
      n = 100000;
    end else if (e < 126) begin
      n = 0;
    end else begin
      sig  = longint'({1'b1, x[22:0]});
      d    = 150 - e;
      q0   = sig >> d;
      r    = sig - (q0 << d);
      half = longint'(1) << (d - 1);
      if (r > half || (r == half && (q0 % 2) == 1)) q0 = q0 + 1;
      n = q0;
    end
    if (n > MAX_INT) begin
      n = MAX_INT;
      c = 1'b1;
    end
    if (n == 0) return;
    p = 0;
    while ((longint'(1) << (p + 1)) <= n) p++;
    o = {s, 8'(127 + p), 23'((n - (longint'(1) << p)) << (23 - p))};
  endfunction

  function automatic logic [31:0] rand_fp();
    int          sel;
    logic [7:0]  e;
    logic [22:0] m;
    logic        s;
    sel = int'($urandom_range(0, 15));
    m   = 23'($urandom);
    s   = 1'($urandom);
    if (sel == 0) begin
      e = 8'd255;
      if ($urandom_range(0, 1) == 0) m = '0;
    end else if (sel == 1) begin
      e = 8'd0;
    end else if (sel == 2) begin
      e = 8'($urandom_range(135, 254));
    end else if (sel < 6) begin
      e = 8'($urandom_range(126, 134));
      m = m & 23'h7F0000;
    end else begin
      e = 8'($urandom_range(120, 136));
    end
    return {s, e, m};
  endfunction

  // Output monitor: every cycle valid_out must match the scoreboard schedule
  always @(negedge clk) begin
    bit ev;
    ev = (q.size() > 0) && (q[0].due == cyc);
    chk("valid_out", {31'b0, valid_a}, {31'b0, ev});
    chk("valid_out_s", {31'b0, valid_b}, {31'b0, ev});
    if (ev) begin
      chk("out", out_a, q[0].o);
      chk("clamped", {31'b0, clamped_a}, {31'b0, q[0].c});
      chk("out_s", out_b, q[0].o);
      chk("clamped_s", {31'b0, clamped_b}, {31'b0, q[0].c});
      if (q[0].c) cnt_model++;
      void'(q.pop_front());
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] eo, input bit ec);
    exp_t t;
    @(posedge clk);
    #1;
    valid_in = 1'b1;
    in       = x;
    t.due    = cyc + 2;
    t.o      = eo;
    t.c      = ec;
    q.push_back(t);
  endtask

  task automatic send_m(input logic [31:0] x);
    logic [31:0] eo;
    bit          ec;
    model(x, eo, ec);
    send(x, eo, ec);
  endtask

  task automatic gap();
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    in       = $urandom;
  endtask

  task automatic drain();
    int k;
    k = 0;
    gap();
    while (q.size() > 0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_cmp++;
    assert (q.size() == 0) else begin
      n_err++;
      $error("FAIL drain: observed %0d pending expected 0", q.size());
    end
  endtask

  task automatic check_counts();
    int sat;
    sat = (cnt_model > 15) ? 15 : cnt_model;
    chk("clamp_count", {16'b0, count_a}, 32'(cnt_model));
    chk("clamp_count_s", {28'b0, count_b}, 32'(sat));
  endtask

  task automatic check_reset_state();
    chk("rst_out", out_a, 32'h0);
    chk("rst_valid", {31'b0, valid_a}, 32'h0);
    chk("rst_clamped", {31'b0, clamped_a}, 32'h0);
    chk("rst_count", {16'b0, count_a}, 32'h0);
    chk("rst_out_s", out_b, 32'h0);
    chk("rst_count_s", {28'b0, count_b}, 32'h0);
  endtask

  // Reset takes effect on the next edge; anything due after that edge is lost
  task automatic do_reset();
    exp_t keep[$];
    @(posedge clk);
    #1;
    reset    = 1'b1;
    valid_in = 1'b0;
    foreach (q[i]) if (q[i].due <= cyc) keep.push_back(q[i]);
    q = keep;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    cnt_model = 0;
    check_reset_state();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t keep[$];
    reset    = 1'b1;
    valid_in = 1'b0;
    in       = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b0;

    // Basic rounding and latency, gap preserved
    send(32'h4019999A, 32'h40000000, 1'b0);
    gap();
    send(32'hC0F33333, 32'hC1000000, 1'b0);
    drain();

    // Ties to even, back-to-back
    send(32'h3F000000, 32'h00000000, 1'b0);
    send(32'h3FC00000, 32'h40000000, 1'b0);
    send(32'h40200000, 32'h40000000, 1'b0);
    send(32'h40600000, 32'h40800000, 1'b0);
    drain();

    // Zero, small and denormal
    send(32'h80000000, 32'h00000000, 1'b0);
    send(32'hBECCCCCD, 32'h00000000, 1'b0);
    send(32'h00000001, 32'h00000000, 1'b0);
    drain();
    check_counts();

    // Saturation and specials from a clean count
    do_reset();
    send(32'h42C80000, 32'h41F80000, 1'b1);
    send(32'hFF800000, 32'hC1F80000, 1'b1);
    send(32'h7FC00000, 32'h00000000, 1'b1);
    send(32'h41FB3333, 32'h41F80000, 1'b0);
    send(32'h41FC0000, 32'h41F80000, 1'b1);
    drain();
    chk("count_after_specials", {16'b0, count_a}, 32'd4);
    check_counts();

    // Reset mid-stream: third sample presented together with reset
    send(32'h40400000, 32'h40400000, 1'b0);
    send(32'hC0A00000, 32'hC0A00000, 1'b0);
    @(posedge clk);
    #1;
    valid_in = 1'b1;
    in       = 32'h42C80000;
    reset    = 1'b1;
    foreach (q[i]) if (q[i].due <= cyc) keep.push_back(q[i]);
    q = keep;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (1) @(posedge clk);
    #1;
    reset     = 1'b0;
    cnt_model = 0;
    check_reset_state();
    drain();
    repeat (4) gap();
    check_counts();

    // Randomized traffic with gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 3) gap();
      else send_m(rand_fp());
    end
    drain();
    check_counts();

    // Counter saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 20; i++) send_m(32'h447A0000);
    drain();
    chk("count_s_saturated", {28'b0, count_b}, 32'd15);
    repeat (3) gap();
    check_counts();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
